// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset/lock sequencer gating the system reset; define PLL_RST_SEQ_AUTORETRY_EN to retry lock timeouts forever instead of entering FAIL
module pll_rst_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clr_flags,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       lock_lost,
  output logic       fail
);
  localparam int MAX_AB = PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_C  = MAX_AB > LOCK_TIMEOUT_CYCLES ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] LD_RESET  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LD_WAIT   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LD_STABLE = CW'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_RST_SEQ_AUTORETRY_EN
  localparam bit AUTORETRY = 1'b1;
`else
  localparam bit AUTORETRY = 1'b0;
`endif
  typedef enum logic [2:0] {S_RESET, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync_q, lk_q;
  logic [3:0]      retry_d;
  logic            lost_d, inc, set, expired;
  assign expired = cnt_q == '0;
  // next state, shared-counter reload on entry, flag updates (set/increment beat clear)
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    set     = 1'b0;
    case (state_q)
      S_RESET:  if (expired) state_d = S_WAIT;
      S_WAIT:   if (lk_q) state_d = S_STABLE;
                else if (expired) begin
                  inc     = 1'b1;
                  state_d = AUTORETRY ? S_RESET : S_FAIL;
                end
      S_STABLE: if (!lk_q) state_d = S_WAIT;
                else if (expired) state_d = S_RUN;
      S_RUN:    if (!lk_q) begin
                  state_d = S_RESET;
                  inc     = 1'b1;
                  set     = 1'b1;
                end
      S_FAIL:   state_d = S_FAIL;
      default:  state_d = S_RESET;
    endcase
    cnt_d   = state_d != state_q ? (state_d == S_RESET ? LD_RESET :
                                    state_d == S_WAIT ? LD_WAIT :
                                    state_d == S_STABLE ? LD_STABLE : '0)
                                 : cnt_q - CW'(!expired);
    retry_d = inc ? (clr_flags ? 4'd1 : retry_cnt + 4'(retry_cnt != 4'd15))
                  : (clr_flags ? 4'd0 : retry_cnt);
    lost_d  = set | (lock_lost & ~clr_flags);
  end
  // state, counter, lock synchronizer, flags and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= LD_RESET;
      sync_q    <= 1'b0;
      lk_q      <= 1'b0;
      retry_cnt <= 4'd0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync_q    <= pll_locked;
      lk_q      <= sync_q;
      retry_cnt <= retry_d;
      lock_lost <= lost_d;
      pll_rst   <= state_d == S_RESET || state_d == S_FAIL;
      sys_rst   <= state_d != S_RUN;
      ready     <= state_d == S_RUN;
      fail      <= state_d == S_FAIL;
    end
  end
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed and randomized checks of pll_rst_seq against an elapsed-time reference model
module tb_pll_rst_seq;
  localparam int PRC = 4;
  localparam int LS  = 8;
  localparam int TO  = 32;
`ifdef PLL_RST_SEQ_AUTORETRY_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam logic [2:0] P_RST = 3'd0, P_WT = 3'd1, P_ST = 3'd2, P_RUN = 3'd3, P_FL = 3'd4;
  localparam logic [8:0] RST_VEC = 9'b1_1_0_0_0_0000;

  typedef struct packed {
    logic [2:0] ph;
    int         el;
    logic       s1;
    logic       s2;
    logic       lost;
    logic [3:0] retry;
  } mdl_t;

  logic       refclk = 1'b0, rst = 1'b1, pll_locked = 1'b0, clr_flags = 1'b0;
  logic       pll_rst, sys_rst, ready, lock_lost, fail;
  logic [3:0] retry_cnt;
  int         checks = 0, errors = 0;
  mdl_t       m = '0;
  wire  [8:0] actv = {pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt};

  pll_rst_seq #(.PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(TO)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .clr_flags(clr_flags),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .retry_cnt(retry_cnt),
    .lock_lost(lock_lost), .fail(fail)
  );

  always #5 refclk = ~refclk;

  // Reference: phase plus cycles elapsed since entering it; lock seen through a two-deep history.
  function automatic mdl_t step(mdl_t c, logic r, logic pl, logic clr);
    mdl_t n   = c;
    logic lk  = c.s2;
    logic inc = 1'b0;
    logic set = 1'b0;
    if (r) return '0;
    n.s2 = c.s1;
    n.s1 = pl;
    n.el = c.el + 1;
    case (c.ph)
      P_RST: if (n.el == PRC) n.ph = P_WT;
      P_WT:  if (lk) n.ph = P_ST;
             else if (n.el == TO) begin inc = 1'b1; n.ph = AUTO ? P_RST : P_FL; end
      P_ST:  if (!lk) n.ph = P_WT;
             else if (n.el == LS) n.ph = P_RUN;
      P_RUN: if (!lk) begin n.ph = P_RST; inc = 1'b1; set = 1'b1; end
      default: ;
    endcase
    if (n.ph != c.ph) n.el = 0;
    n.retry = inc ? (clr ? 4'd1 : (c.retry == 4'd15 ? 4'd15 : c.retry + 4'd1)) : (clr ? 4'd0 : c.retry);
    n.lost  = set | (c.lost & ~clr);
    return n;
  endfunction

  always @(posedge refclk) m <= step(m, rst, pll_locked, clr_flags);

  function automatic logic [8:0] expv();
    return {m.ph == P_RST || m.ph == P_FL, m.ph != P_RUN, m.ph == P_RUN, m.ph == P_FL, m.lost, m.retry};
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pll_locked = 1'b0; clr_flags = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'($urandom_range(1)); clr_flags = 1'b0;
    tick(); tick();
    checks++;
    if (actv !== RST_VEC) begin errors++; $display("FAIL reset_values act=%b exp=%b", actv, RST_VEC); end
    rst = 1'b0;
  endtask

  task automatic test_bringup();
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      tick();
      checks++;
      if (actv !== expv()) begin errors++; $display("FAIL bringup_model e%0d act=%b exp=%b", e, actv, expv()); end
      if (e == 3) begin checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL bringup_pll_rst_e3 act=%b exp=1", pll_rst); end end
      if (e == 4) begin checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL bringup_pll_rst_e4 act=%b exp=0", pll_rst); end end
      if (e == 20) begin checks++; if (ready !== 1'b0) begin errors++; $display("FAIL bringup_ready_e20 act=%b exp=0", ready); end end
      if (e == 21) begin
        checks++;
        if ({ready, sys_rst, retry_cnt} !== 6'b1_0_0000) begin
          errors++; $display("FAIL bringup_run_e21 act=%b exp=%b", {ready, sys_rst, retry_cnt}, 6'b1_0_0000);
        end
      end
      if (e == 10) pll_locked = 1'b1;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      tick();
      checks++;
      if (actv !== expv()) begin errors++; $display("FAIL glitch_model e%0d act=%b exp=%b", e, actv, expv()); end
      checks++;
      if (ready !== (e >= 29)) begin errors++; $display("FAIL glitch_ready e%0d act=%b exp=%b", e, ready, e >= 29); end
      if (e == 10) pll_locked = 1'b1;
      if (e == 13) pll_locked = 1'b0;
      if (e == 18) pll_locked = 1'b1;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    if (AUTO) begin
      for (int e = 1; e <= 36 * 16; e++) begin
        tick();
        checks++;
        if (actv !== expv()) begin errors++; $display("FAIL timeout_model e%0d act=%b exp=%b", e, actv, expv()); end
        if (e % 36 == 4) begin checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL timeout_pll_rst_low e%0d act=%b exp=0", e, pll_rst); end end
        if (e % 36 == 0) begin
          checks++;
          if ({pll_rst, retry_cnt} !== {1'b1, 4'((e / 36) > 15 ? 15 : e / 36)}) begin
            errors++; $display("FAIL timeout_retry e%0d act=%b/%0d exp=1/%0d", e, pll_rst, retry_cnt, (e / 36) > 15 ? 15 : e / 36);
          end
        end
      end
    end else begin
      for (int e = 1; e <= 60; e++) begin
        tick();
        checks++;
        if (actv !== expv()) begin errors++; $display("FAIL timeout_model e%0d act=%b exp=%b", e, actv, expv()); end
        if (e == 35) begin checks++; if ({fail, pll_rst} !== 2'b00) begin errors++; $display("FAIL timeout_e35 act=%b exp=00", {fail, pll_rst}); end end
        if (e == 36 || e == 60) begin
          checks++;
          if (actv !== 9'b1_1_0_1_0_0001) begin errors++; $display("FAIL timeout_fail e%0d act=%b exp=%b", e, actv, 9'b1_1_0_1_0_0001); end
        end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (actv !== RST_VEC) begin errors++; $display("FAIL timeout_rst_exit act=%b exp=%b", actv, RST_VEC); end
    end
  endtask

  task automatic test_lock_loss();
    do_reset();
    for (int e = 1; e <= 45; e++) begin
      tick();
      checks++;
      if (actv !== expv()) begin errors++; $display("FAIL loss_model e%0d act=%b exp=%b", e, actv, expv()); end
      if (e == 27) begin checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_ready_e27 act=%b exp=1", ready); end end
      if (e == 28) begin
        checks++;
        if ({sys_rst, ready, pll_rst, lock_lost, retry_cnt} !== 8'b1_0_1_1_0001) begin
          errors++; $display("FAIL loss_e28 act=%b exp=%b", {sys_rst, ready, pll_rst, lock_lost, retry_cnt}, 8'b1_0_1_1_0001);
        end
      end
      if (e == 40) begin checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready_e40 act=%b exp=0", ready); end end
      if (e == 41) begin checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_ready_e41 act=%b exp=1", ready); end end
      if (e == 42) begin
        checks++;
        if ({lock_lost, retry_cnt} !== 5'b0_0000) begin errors++; $display("FAIL loss_clr act=%b exp=00000", {lock_lost, retry_cnt}); end
      end
      if (e == 10) pll_locked = 1'b1;
      if (e == 25) pll_locked = 1'b0;
      if (e == 27) clr_flags = 1'b1;
      if (e == 28) begin clr_flags = 1'b0; pll_locked = 1'b1; end
      if (e == 41) clr_flags = 1'b1;
      if (e == 42) clr_flags = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    int n;
    pll_locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (m.ph != P_RST && n < 10);
    checks++;
    if (actv !== expv() || m.ph != P_RST) begin errors++; $display("FAIL mid_drop act=%b exp=%b waited=%0d", actv, expv(), n); end
    pll_locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (m.ph != P_ST && n < 100);
    tick();
    checks++;
    if (actv !== expv() || m.ph != P_ST || lock_lost !== 1'b1) begin
      errors++; $display("FAIL mid_stable act=%b exp=%b waited=%0d", actv, expv(), n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (actv !== RST_VEC) begin errors++; $display("FAIL mid_rst act=%b exp=%b", actv, RST_VEC); end
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (pll_rst !== (e < 4)) begin errors++; $display("FAIL mid_reload e%0d act=%b exp=%b", e, pll_rst, e < 4); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(23) == 0) pll_locked = ~pll_locked;
      clr_flags = $urandom_range(31) == 0;
      rst = $urandom_range(399) == 0;
      tick();
      checks++;
      if (actv !== expv()) begin errors++; $display("FAIL random_model i%0d act=%b exp=%b", i, actv, expv()); end
    end
    rst = 1'b0; clr_flags = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_timeout();
    test_lock_loss();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

Reset and lock sequencer for the system PLL. Runs on the 50 MHz reference clock, drives the PLL reset, and waits for a debounced lock before releasing the synchronous system reset and asserting `ready`. On lock timeout it retries; on loss of lock after release it re-sequences. Sits between the board reset/clock input and the PLL wrapper, and feeds reset to the NES core.

## Interface
- `PLL_RST_CYCLES`, 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: max cycles in WAIT_LOCK before timeout (≥1).
- `refclk`  in  1  reference clock, 50 MHz; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  PLL lock; asynchronous to refclk.
- `clr_flags`  in  1  one-cycle pulse; clears `lock_lost` and `retry_cnt`.
- `pll_rst`  out  1  PLL reset, active-high.
- `sys_rst`  out  1  system reset, active-high, refclk domain.
- `ready`  out  1  high only in RUN.
- `retry_cnt`  out  4  saturating count of timeouts and lock losses.
- `lock_lost`  out  1  sticky; set on lock drop in RUN.
- `fail`  out  1  high only in FAIL state (see Configuration).

## Operation
- `pll_locked` passes through a 2-flop synchronizer, giving `lk`. Synchronizer flops reset to 0.
- One shared down-counter, width covering max(parameters); it is reloaded on every state entry.
- States:
  - RESET: `pll_rst`=1, `sys_rst`=1. After `PLL_RST_CYCLES` cycles → WAIT_LOCK.
  - WAIT_LOCK: `pll_rst`=0, `sys_rst`=1.
    - `lk`=1 → STABLE.
    - Counter expiry after `LOCK_TIMEOUT_CYCLES` cycles without `lk` → increment `retry_cnt`, then RESET (or FAIL; see Configuration).
  - STABLE: `sys_rst`=1.
    - `lk`=0 → WAIT_LOCK, with the timeout counter reloaded.
    - `LOCK_STABLE_CYCLES` consecutive cycles with `lk`=1 → RUN.
  - RUN: `sys_rst`=0, `ready`=1.
    - `lk`=0 → RESET; set `lock_lost`; increment `retry_cnt`.
  - FAIL: `pll_rst`=1, `sys_rst`=1, `fail`=1. Exits only on `rst`.
- `retry_cnt` saturates at 15.
- If `clr_flags` and an increment or set happen in the same cycle, the increment or set wins: `retry_cnt`=1, `lock_lost`=1.
- `rst` asserted in any state, including mid-sequence: the next edge enters RESET, counters reload, and flags and synchronizer clear.

## Timing
- Reset values:
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0.
  - `retry_cnt`=0, `lock_lost`=0.
  - state=RESET.
- All outputs are registered; each output changes on the edge that enters the new state.
- First `rst`-low edge starts RESET; `pll_rst` falls exactly `PLL_RST_CYCLES` edges later.
- Latency from `pll_locked` rise to `lk` rise is 2 edges. STABLE is entered on the edge after `lk` is sampled high.
- `sys_rst` falls and `ready` rises `LOCK_STABLE_CYCLES` edges after STABLE entry.
- In RUN, `lk` low sampled → next edge: `sys_rst`=1, `ready`=0, `pll_rst`=1. Worst case is 3 edges after `pll_locked` falls.
- `sys_rst` is not synchronized to `outclk_0`; consumers re-synchronize it.

## Configuration
- `PLL_RST_SEQ_AUTORETRY_EN`:
  - Defined: WAIT_LOCK timeout → RESET, and retries continue indefinitely.
  - Undefined: WAIT_LOCK timeout → FAIL, with `retry_cnt` incremented once.
  - Lock loss in RUN goes to RESET in both builds.

## Test plan
Parameters for all cases: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
- Normal bring-up: release `rst`, raise `pll_locked` at edge 10 → `pll_rst` falls at edge 4; `ready`=1 and `sys_rst`=0 at edge 21; `retry_cnt`=0.
- Glitchy lock: pulse `pll_locked` high for 3 cycles, then low, then steady high → no `ready` during the glitch; `ready` rises 8 edges after the second STABLE entry.
- Timeout, AUTORETRY defined: hold `pll_locked`=0 → `pll_rst` re-asserts 32 edges after falling; `retry_cnt` = 1, 2, 3…, saturating at 15 after 15 timeouts.
- Timeout, macro undefined: hold `pll_locked`=0 → after 32 edges, `fail`=1, `pll_rst`=1, `retry_cnt`=1. The block stays in FAIL until `rst`; `rst` returns all outputs to reset values.
- Lock loss in RUN: drop `pll_locked` → within 3 edges `sys_rst`=1, `ready`=0, `lock_lost`=1, `retry_cnt`=1, then full re-sequence. A `clr_flags` pulse on the same edge as the set leaves `lock_lost`=1.
- Mid-sequence reset: assert `rst` for 1 cycle during STABLE → next edge enters RESET with the counter reloaded; flags return to 0.
